conv8_32: RTL
=============

CONV8_32 -- requirements
Module: conv8_32

Interface
REQ-001 Parameters: none; widths fixed at 8-bit in, 32-bit out.
REQ-002 clk_4f  input  1  single clock; all state changes on rising edge.
REQ-003 reset_L  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
REQ-004 in_data  input  8  byte lane; sampled only when in=1.
REQ-005 in  input  1  byte-valid; 1 = in_data holds a valid byte this cycle.
REQ-006 out_data  output  32  assembled word, registered; held until the next completed word.
REQ-007 out  output  1  word-valid; one-cycle pulse per completed word, registered.
REQ-008 byte_idx  output  2  registered count of bytes already captured in the current word (0-3).
REQ-009 err  output  1  abort pulse; behaviour defined under Configuration.

Function
REQ-010 The block SHALL deserialize four consecutive valid bytes into one 32-bit word, first byte to [31:24], then [23:16], [15:8], last to [7:0].
REQ-011 The FSM SHALL have two states: IDLE (byte_idx=0, no partial word) and COLLECT (1-3 bytes held).
REQ-012 IDLE with in=1 SHALL capture in_data into partial bits [23:16], set byte_idx=1 and go to COLLECT; IDLE with in=0 SHALL stay in IDLE.
REQ-013 COLLECT with in=1 and byte_idx<3 SHALL shift in_data into the partial register and increment byte_idx.
REQ-014 COLLECT with in=1 and byte_idx=3 SHALL load out_data={partial[23:0],in_data} and set out=1 on the same edge, set byte_idx=0 and go to IDLE; latency is 1 edge after the fourth byte is sampled.
REQ-015 out SHALL be 0 on every edge that does not complete a word; back-to-back words with in held at 1 SHALL give one out pulse every 4 cycles with no gap cycles.
REQ-016 COLLECT with in=0 SHALL abort: discard the partial word, clear the partial register, set byte_idx=0, go to IDLE, and leave out_data unchanged with out=0.
REQ-017 A new byte arriving on the cycle after an abort SHALL be treated as byte 0 of a new word.
REQ-018 byte_idx SHALL wrap 3->0 only on word completion and never exceed 3.
REQ-019 in_data SHALL be ignored whenever in=0.

Reset
REQ-020 While reset_L=0: out_data=32'h0, out=0, err=0, byte_idx=0, partial register=0, FSM=IDLE.
REQ-021 Reset asserted mid-word SHALL discard the partial word without raising out or err.
REQ-022 On the first edge after reset_L rises, the block SHALL behave as in IDLE.

Configuration
REQ-023 Macro CONV8_32_ERR_EN defined: err SHALL pulse 1 for exactly one cycle on the edge that performs a REQ-016 abort, and stay 0 otherwise.
REQ-024 Macro CONV8_32_ERR_EN undefined: err SHALL be tied constant 0, with no abort-detect logic; all other behaviour is identical.

Verification
REQ-025 Reset release, then in=1 with bytes DE,AD,BE,EF on 4 edges -> on the 4th edge out_data=32'hDEADBEEF, out=1 for one cycle, byte_idx=0.
REQ-026 in held at 1 for 8 bytes 01..08 -> out pulses on edges 4 and 8 with out_data=32'h01020304 then 32'h05060708, and no idle cycle between words.
REQ-027 Bytes 11,22, then in=0 for 1 cycle, then bytes AA,BB,CC,DD -> err=1 on the abort edge (ERR_EN defined) and the next word is 32'hAABBCCDD; the prior out_data is unchanged until then.
REQ-028 Same stimulus as REQ-027 with CONV8_32_ERR_EN undefined -> err stays 0 and the word is still 32'hAABBCCDD.
REQ-029 reset_L pulsed low asynchronously after 3 bytes -> all outputs go 0 immediately; the next 4 bytes 12,34,56,78 produce 32'h12345678.
REQ-030 in=0 with random in_data for 10 cycles -> out=0, err=0, byte_idx=0 throughout.

Source files
------------

// File: rtl/conv8_32.sv
// ---------------------------------------------------------------------------
// conv8_32 -- byte-to-word deserializer
//
// Collects four consecutive valid bytes and presents them as one 32-bit
// word. The first byte of a word ends up in out_data[31:24] and the last
// byte in out_data[7:0]. A gap (in=0) in the middle of a word abandons the
// partial word, and the next valid byte starts a fresh word.
//
// Ports
//   clk_4f    in   1   single clock, rising-edge active
//   reset_L   in   1   asynchronous, active-low reset
//   in_data   in   8   byte lane, only looked at while in=1
//   in        in   1   byte-valid qualifier for in_data
//   out_data  out  32  last completed word, registered, held between words
//   out       out  1   one-cycle pulse on the edge that completes a word
//   byte_idx  out  2   bytes already captured for the word in progress (0-3)
//   err       out  1   one-cycle pulse on the edge that abandons a word
//
// Configuration
//   CONV8_32_ERR_EN  defined   : err pulses on every aborted partial word.
//                    undefined : err is a constant 0 and the abort detector
//                                is not built.
// ---------------------------------------------------------------------------
module conv8_32 (
    input  logic        clk_4f,
    input  logic        reset_L,
    input  logic [7:0]  in_data,
    input  logic        in,
    output logic [31:0] out_data,
    output logic        out,
    output logic [1:0]  byte_idx,
    output logic        err
);

    // IDLE holds no bytes; COLLECT holds one to three bytes of a word.
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t      state_q,    state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] partial_q,  partial_d;
    logic [31:0] out_data_q, out_data_d;
    logic        out_q,      out_d;

`ifdef CONV8_32_ERR_EN
    logic        err_q,      err_d;
`endif

    // State register and all output/datapath flops. Reset is asynchronous
    // so that a word in flight is thrown away the moment reset_L drops,
    // without waiting for a clock edge.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= IDLE;
            byte_idx_q <= 2'd0;
            partial_q  <= 24'h0;
            out_data_q <= 32'h0;
            out_q      <= 1'b0;
`ifdef CONV8_32_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            partial_q  <= partial_d;
            out_data_q <= out_data_d;
            out_q      <= out_d;
`ifdef CONV8_32_ERR_EN
            err_q      <= err_d;
`endif
        end
    end

    // Next-state logic. COLLECT returns to IDLE either when the fourth byte
    // completes the word or when the byte stream stalls (abort).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (!in || (byte_idx_q == 2'd3)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath logic. The partial register is filled from its
    // top byte downward, so after three bytes it already holds the upper
    // 24 bits of the finished word and the fourth byte is simply appended.
    // Aborting clears the partial register so no stale byte can leak into
    // a later word.
    always_comb begin
        byte_idx_d = byte_idx_q;
        partial_d  = partial_q;
        out_data_d = out_data_q;
        out_d      = 1'b0;
`ifdef CONV8_32_ERR_EN
        err_d      = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (in) begin
                    partial_d  = {in_data, 16'h0};
                    byte_idx_d = 2'd1;
                end
            end
            COLLECT: begin
                if (in) begin
                    if (byte_idx_q == 2'd3) begin
                        out_data_d = {partial_q, in_data};
                        out_d      = 1'b1;
                        partial_d  = 24'h0;
                        byte_idx_d = 2'd0;
                    end else begin
                        if (byte_idx_q == 2'd1) begin
                            partial_d[15:8] = in_data;
                        end else begin
                            partial_d[7:0]  = in_data;
                        end
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end else begin
                    partial_d  = 24'h0;
                    byte_idx_d = 2'd0;
`ifdef CONV8_32_ERR_EN
                    err_d      = 1'b1;
`endif
                end
            end
            default: begin
                partial_d  = 24'h0;
                byte_idx_d = 2'd0;
            end
        endcase
    end

    assign out_data = out_data_q;
    assign out      = out_q;
    assign byte_idx = byte_idx_q;

`ifdef CONV8_32_ERR_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
